// File: rtl/matrix_rx_parser_if.sv
// Byte-stream input and element/matrix/error outputs of the matrix receive parser.
// master drives the UART bytes; slave is the parser.
interface matrix_rx_parser_if #(
    parameter int DATA_W = 8,
    parameter int SLOT_W = 3
);
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              elem_we;
    logic [SLOT_W-1:0] elem_slot;
    logic [3:0]        elem_row;
    logic [3:0]        elem_col;
    logic [DATA_W-1:0] elem_data;
    logic              elem_sat;
    logic              mat_done;
    logic [SLOT_W-1:0] mat_slot;
    logic [3:0]        mat_rows;
    logic [3:0]        mat_cols;
    logic              err_pulse;
    logic [1:0]        err_code;
    logic              busy;

    modport master (
        output rx_data, rx_done,
        input  elem_we, elem_slot, elem_row, elem_col, elem_data, elem_sat,
        input  mat_done, mat_slot, mat_rows, mat_cols, err_pulse, err_code, busy
    );

    modport slave (
        input  rx_data, rx_done,
        output elem_we, elem_slot, elem_row, elem_col, elem_data, elem_sat,
        output mat_done, mat_slot, mat_rows, mat_cols, err_pulse, err_code, busy
    );
endinterface

// File: rtl/matrix_rx_parser.sv
// Parses "rows cols e0 .. eN" decimal tokens from a UART byte stream into slotted matrix storage.
// Define RX_TIMEOUT_EN to add the inter-byte timeout (err_code 3).
//
// state  | meaning
// S_IDLE | waiting for the rows token
// S_COLS | rows latched, waiting for the cols token
// S_ELEM | streaming elements in row-major order
module matrix_rx_parser #(
    parameter int MAX_DIM     = 5,
    parameter int DATA_W      = 8,
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_W      = 3,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    matrix_rx_parser_if.slave bus
);
    localparam logic [DATA_W-1:0] SAT_VAL   = '1;
    localparam logic [DATA_W-1:0] DIM_MAX   = DATA_W'(MAX_DIM);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

    if (MAX_DIM < 1 || MAX_DIM > 15) begin : g_bad_max_dim
        $error("MAX_DIM must be 1..15");
    end
    if ((1 << SLOT_W) < NUM_SLOTS || NUM_SLOTS < 1) begin : g_bad_slot_w
        $error("SLOT_W too narrow for NUM_SLOTS");
    end
    if (DATA_W < 4) begin : g_bad_data_w
        $error("DATA_W must hold a dimension");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be positive");
    end

    typedef enum logic [1:0] {S_IDLE, S_COLS, S_ELEM} state_t;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic              have_digit;
    logic              sat;
    logic [3:0]        rows_q;
    logic [3:0]        cols_q;
    logic [3:0]        row;
    logic [3:0]        col;
    logic [SLOT_W-1:0] slot;

    logic              is_digit;
    logic              is_sep;
    logic              acc_clamp;
    logic              dim_ok;
    logic              last_col;
    logic              last_row;
    logic [DATA_W+3:0] acc_wide;

    always_comb begin
        is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        case (bus.rx_data)
            8'h20, 8'h2C, 8'h0D, 8'h0A, 8'h09: is_sep = 1'b1;
            default:                           is_sep = 1'b0;
        endcase
        // acc*10 + d in DATA_W+4 bits cannot wrap, so the clamp compare is exact
        acc_wide  = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                  + {{DATA_W{1'b0}}, bus.rx_data[3:0]};
        acc_clamp = acc_wide > {4'b0000, SAT_VAL};
        dim_ok    = (acc != '0) && (acc <= DIM_MAX);
        last_col  = (col == cols_q - 4'd1);
        last_row  = (row == rows_q - 4'd1);
    end

`ifdef RX_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= TMO_LOAD;
        end else if (bus.rx_done) begin
            tmo_cnt <= TMO_LOAD;
        end else if (bus.busy && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    assign tmo_hit = bus.busy && !bus.rx_done && (tmo_cnt == '0);
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            acc           <= '0;
            have_digit    <= 1'b0;
            sat           <= 1'b0;
            rows_q        <= '0;
            cols_q        <= '0;
            row           <= '0;
            col           <= '0;
            slot          <= '0;
            bus.elem_we   <= 1'b0;
            bus.elem_slot <= '0;
            bus.elem_row  <= '0;
            bus.elem_col  <= '0;
            bus.elem_data <= '0;
            bus.elem_sat  <= 1'b0;
            bus.mat_done  <= 1'b0;
            bus.mat_slot  <= '0;
            bus.mat_rows  <= '0;
            bus.mat_cols  <= '0;
            bus.err_pulse <= 1'b0;
            bus.err_code  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.elem_we   <= 1'b0;
            bus.mat_done  <= 1'b0;
            bus.err_pulse <= 1'b0;

            if (bus.rx_done && !is_digit && !is_sep) begin
                bus.err_pulse <= 1'b1;
                bus.err_code  <= 2'd1;
                bus.busy      <= 1'b0;
                state         <= S_IDLE;
                acc           <= '0;
                have_digit    <= 1'b0;
                sat           <= 1'b0;
            end else if (bus.rx_done && is_digit) begin
                acc        <= acc_clamp ? SAT_VAL : acc_wide[DATA_W-1:0];
                have_digit <= 1'b1;
                if (acc_clamp) begin
                    sat <= 1'b1;
                end
                if (state == S_IDLE) begin
                    bus.busy <= 1'b1;
                end
            end else if (bus.rx_done && is_sep && have_digit) begin
                acc        <= '0;
                have_digit <= 1'b0;
                sat        <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (dim_ok) begin
                            rows_q <= acc[3:0];
                            state  <= S_COLS;
                        end else begin
                            bus.err_pulse <= 1'b1;
                            bus.err_code  <= 2'd2;
                            bus.busy      <= 1'b0;
                        end
                    end
                    S_COLS: begin
                        if (dim_ok) begin
                            cols_q <= acc[3:0];
                            row    <= '0;
                            col    <= '0;
                            state  <= S_ELEM;
                        end else begin
                            bus.err_pulse <= 1'b1;
                            bus.err_code  <= 2'd2;
                            bus.busy      <= 1'b0;
                            state         <= S_IDLE;
                        end
                    end
                    S_ELEM: begin
                        bus.elem_we   <= 1'b1;
                        bus.elem_slot <= slot;
                        bus.elem_row  <= row;
                        bus.elem_col  <= col;
                        bus.elem_data <= acc;
                        bus.elem_sat  <= sat;
                        if (last_col) begin
                            col <= '0;
                            row <= row + 4'd1;
                        end else begin
                            col <= col + 4'd1;
                        end
                        if (last_col && last_row) begin
                            bus.mat_done <= 1'b1;
                            bus.mat_slot <= slot;
                            bus.mat_rows <= rows_q;
                            bus.mat_cols <= cols_q;
                            bus.busy     <= 1'b0;
                            slot         <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
                            state        <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (tmo_hit) begin
                bus.err_pulse <= 1'b1;
                bus.err_code  <= 2'd3;
                bus.busy      <= 1'b0;
                state         <= S_IDLE;
                acc           <= '0;
                have_digit    <= 1'b0;
                sat           <= 1'b0;
            end
        end
    end
endmodule
